if_id_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.

---
 rtl/if_id_fetch_stage_pkg.sv | 20 ++
 rtl/if_id_fetch_stage_if.sv | 22 ++
 rtl/if_id_fetch_stage_if_id_reg.sv | 40 ++++
 rtl/if_id_fetch_stage.sv | 102 ++++++++++
 tb/tb_if_id_fetch_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/if_id_fetch_stage_pkg.sv
// ============================================================================
// Package  : mips_pkg
// Purpose  : Shared constants and fetch FSM encoding for the MIPS pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;
    localparam int          PC_W      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OPC_LW    = 6'b100011;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/if_id_fetch_stage_if.sv
// ============================================================================
// Interface : if_id_fetch_stage_if
// Purpose   : Instruction-memory request/ready bus between fetch and imem.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_id_fetch_stage_if;
    import mips_pkg::*;

    logic [PC_W-1:0] Imem_addr;
    logic            Imem_req;
    logic [31:0]     Imem_rdata;
    logic            Imem_ready;

    modport master (output Imem_addr, output Imem_req,
                    input  Imem_rdata, input Imem_ready);
    modport slave  (input  Imem_addr, input  Imem_req,
                    output Imem_rdata, output Imem_ready);
endinterface

`default_nettype wire

// File: rtl/if_id_fetch_stage_if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with hold and flush (bubble) controls.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        Clk,
    input  wire logic        Reset_n,
    input  wire logic        hold,
    input  wire logic        flush,
    input  wire logic [31:0] instr_in,
    input  wire logic [31:0] pc4_in,
    output logic      [31:0] instr,
    output logic      [31:0] pc4,
    output logic             valid
);

    // Flush outranks hold so a redirect can squash a stalled instruction.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!hold) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// Module   : if_id_fetch_stage
// Purpose  : MIPS fetch stage: PC, imem handshake FSM, wait timeout, IF/ID.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int          TIMEOUT   = 16
) (
    input  wire logic            Clk,
    input  wire logic            Reset_n,
    input  wire logic            IF_ID_stall,
    input  wire logic            Redirect,
    input  wire logic [31:0]     Redirect_pc,
    if_id_fetch_stage_if.master  bus,
    output logic      [31:0]     PC,
    output logic      [31:0]     IF_ID_instr,
    output logic      [31:0]     IF_ID_pc4,
    output logic                 IF_ID_valid,
    output logic                 Fetch_timeout
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_q;
    logic [31:0]  pc_plus4;
    logic [4:0]   wait_cnt;
    logic         active;
    logic         reg_hold;
    logic         reg_flush;

    assign active    = (state != BOOT);
    assign pc_plus4  = {pc_q[31:2] + 30'd1, 2'b00};
    assign reg_flush = active && (Redirect || (!IF_ID_stall && !bus.Imem_ready));
    assign reg_hold  = !active || IF_ID_stall;

    assign bus.Imem_addr = pc_q;
    assign bus.Imem_req  = active;
    assign PC            = pc_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= BOOT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN:  if (bus.Imem_req && !bus.Imem_ready && !Redirect && !IF_ID_stall)
                      state_next = WAIT;
            WAIT: if (bus.Imem_ready || Redirect)
                      state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q <= {RESET_PC[31:2], 2'b00};
        end else if (active) begin
            if (Redirect)                        pc_q <= {Redirect_pc[31:2], 2'b00};
            else if (!IF_ID_stall && bus.Imem_ready) pc_q <= pc_plus4;
        end
    end

    // Counter only runs while parked in WAIT; Fetch_timeout is sticky until reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt      <= 5'd0;
            Fetch_timeout <= 1'b0;
        end else begin
            if (state == WAIT && state_next == WAIT) begin
                if (wait_cnt != 5'(TIMEOUT)) wait_cnt <= wait_cnt + 5'd1;
            end else begin
                wait_cnt <= 5'd0;
            end
            if (wait_cnt == 5'(TIMEOUT)) Fetch_timeout <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .hold     (reg_hold),
        .flush    (reg_flush),
        .instr_in (bus.Imem_rdata),
        .pc4_in   (pc_plus4),
        .instr    (IF_ID_instr),
        .pc4      (IF_ID_pc4),
        .valid    (IF_ID_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
// ============================================================================
// Module   : tb_if_id_fetch_stage
// Purpose  : Directed self-checking bench for if_id_fetch_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_fetch_stage;
    import mips_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        IF_ID_stall;
    logic        Redirect;
    logic [31:0] Redirect_pc;
    logic [31:0] PC, IF_ID_instr, IF_ID_pc4;
    logic        IF_ID_valid, Fetch_timeout;

    int n_vec = 0;
    int n_err = 0;

    if_id_fetch_stage_if bus ();

    if_id_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .TIMEOUT   (16)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .IF_ID_stall   (IF_ID_stall),
        .Redirect      (Redirect),
        .Redirect_pc   (Redirect_pc),
        .bus           (bus),
        .PC            (PC),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_pc4     (IF_ID_pc4),
        .IF_ID_valid   (IF_ID_valid),
        .Fetch_timeout (Fetch_timeout)
    );

    always #5 Clk = ~Clk;

    // Memory image: word at address A is 0xA000_0000 | A.
    assign bus.Imem_rdata = 32'hA000_0000 | bus.Imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0; IF_ID_stall = 1'b0; Redirect = 1'b0; Redirect_pc = 32'h0;
        bus.Imem_ready = 1'b1;
        #12;
        check("rst_pc",    PC, 32'h0);
        check("rst_instr", IF_ID_instr, 32'h0);
        check("rst_pc4",   IF_ID_pc4, 32'h0);
        check("rst_valid", 32'(IF_ID_valid), 32'h0);
        check("rst_tmo",   32'(Fetch_timeout), 32'h0);
        check("rst_req",   32'(bus.Imem_req), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Boot bubble, then sequential fetch.
        step();
        check("boot_valid", 32'(IF_ID_valid), 32'h0);
        check("boot_pc",    PC, 32'h0);
        check("boot_req",   32'(bus.Imem_req), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc4",   IF_ID_pc4, 32'(4 * i));
            check("seq_instr", IF_ID_instr, 32'hA000_0000 | 32'(4 * (i - 1)));
            check("seq_valid", 32'(IF_ID_valid), 32'h1);
        end
        check("seq_pc", PC, 32'h10);

        // Two-cycle load-use stall.
        IF_ID_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_pc",    PC, 32'h10);
            check("stall_instr", IF_ID_instr, 32'hA000_000C);
            check("stall_valid", 32'(IF_ID_valid), 32'h1);
        end
        IF_ID_stall = 1'b0;
        step();
        check("unstall_pc",    PC, 32'h14);
        check("unstall_instr", IF_ID_instr, 32'hA000_0010);

        // Redirect wins over stall.
        Redirect = 1'b1; Redirect_pc = 32'h40; IF_ID_stall = 1'b1;
        step();
        Redirect = 1'b0; IF_ID_stall = 1'b0;
        check("redir_pc",    PC, 32'h40);
        check("redir_valid", 32'(IF_ID_valid), 32'h0);
        check("redir_instr", IF_ID_instr, 32'h0);
        step();
        check("post_redir_instr", IF_ID_instr, 32'hA000_0040);
        check("post_redir_pc4",   IF_ID_pc4, 32'h44);

        // Short imem wait.
        bus.Imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_valid", 32'(IF_ID_valid), 32'h0);
            check("wait_pc",    PC, 32'h44);
            check("wait_state", 32'(dut.state), 32'(WAIT));
        end
        bus.Imem_ready = 1'b1;
        step();
        check("wait_done_instr", IF_ID_instr, 32'hA000_0044);
        check("wait_done_valid", 32'(IF_ID_valid), 32'h1);
        check("wait_done_tmo",   32'(Fetch_timeout), 32'h0);
        check("wait_done_pc",    PC, 32'h48);

        // Long wait: TIMEOUT+2 cycles without ready.
        bus.Imem_ready = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i == 17) check("tmo_before", 32'(Fetch_timeout), 32'h0);
        end
        check("tmo_set", 32'(Fetch_timeout), 32'h1);
        bus.Imem_ready = 1'b1;
        step();
        check("tmo_ready_valid", 32'(IF_ID_valid), 32'h1);
        check("tmo_sticky",      32'(Fetch_timeout), 32'h1);

        // Redirect to an unaligned top address, then wrap.
        Redirect = 1'b1; Redirect_pc = 32'hFFFF_FFFF;
        step();
        Redirect = 1'b0;
        check("align_pc", PC, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    PC, 32'h0);
        check("wrap_pc4",   IF_ID_pc4, 32'h0);
        check("wrap_instr", IF_ID_instr, 32'hFFFF_FFFC);
        step();
        check("wrap_next_pc", PC, 32'h4);

        // Asynchronous reset while waiting on imem.
        bus.Imem_ready = 1'b0;
        step();
        step();
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_pc",    PC, 32'h0);
        check("arst_valid", 32'(IF_ID_valid), 32'h0);
        check("arst_instr", IF_ID_instr, 32'h0);
        check("arst_pc4",   IF_ID_pc4, 32'h0);
        check("arst_tmo",   32'(Fetch_timeout), 32'h0);
        check("arst_req",   32'(bus.Imem_req), 32'h0);
        #20;
        Reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
